// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencer between the execute stage and the iterative multdiv unit.
// It accepts one MULT/DIV at a time and latches its operands. It then pulses a
// one-cycle start strobe and stalls the pipeline while the unit works. It ignores
// a stale resultRDY for the first BLANK_CYC wait cycles. If the unit stays silent
// for too long, it forces completion with an exception. It returns a one-cycle
// writeback strobe.
//
// Ports
//   clock, reset                  : rising-edge clock, asynchronous active-high reset
//   op_valid/op_is_div/op_a/op_b/op_rd : request from execute stage
//   flush                         : squash in-flight op
//   md_operandA/B, md_ctrl_MULT/DIV : registered drive to multdiv
//   md_result/md_exception/md_resultRDY : multdiv response
//   stall (comb), busy            : pipeline freeze / sequencer not idle
//   wb_valid/wb_rd/wb_data/wb_exception : writeback to regfile path
module multdiv_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_W      = 5,
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned TIMEOUT   = 63
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_is_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [RD_W-1:0]   op_rd,
    input  logic              flush,
    output logic [DATA_W-1:0] md_operandA,
    output logic [DATA_W-1:0] md_operandB,
    output logic              md_ctrl_MULT,
    output logic              md_ctrl_DIV,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_resultRDY,
    output logic              stall,
    output logic              busy,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_exception
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] BlankCnt   = CntW'(BLANK_CYC);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic              mult_q, mult_d, div_q, div_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_exc_q, wb_exc_d;
    logic              rdy_ok;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        mult_d     = 1'b0;
        div_d      = 1'b0;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_exc_d   = wb_exc_q;
        // A RDY seen during the blank window may belong to a squashed earlier op.
        rdy_ok     = md_resultRDY && (cnt_q >= BlankCnt);

        unique case (state_q)
            StIdle: begin
                if (op_valid && !flush) begin
                    state_d = StIssue;
                    opa_d   = op_a;
                    opb_d   = op_b;
                    rd_d    = op_rd;
                    // Start strobes are registered so they are high exactly in ISSUE.
                    mult_d  = !op_is_div;
                    div_d   = op_is_div;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = flush ? StIdle : StWait;
            end
            StWait: begin
                cnt_d = (cnt_q == TimeoutCnt) ? cnt_q : cnt_q + 1'b1;
                if (flush) begin
                    state_d = StIdle;
                end else if (rdy_ok) begin
                    state_d    = StDone;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = md_result;
                    wb_exc_d   = md_exception;
                end else if (cnt_q == TimeoutCnt) begin
                    state_d    = StDone;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = '0;
                    wb_exc_d   = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rd_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_exc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            mult_q     <= mult_d;
            div_q      <= div_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_exc_q   <= wb_exc_d;
        end
    end

    assign md_operandA  = opa_q;
    assign md_operandB  = opb_q;
    assign md_ctrl_MULT = mult_q;
    assign md_ctrl_DIV  = div_q;
    assign busy         = (state_q != StIdle);
    // A flush arriving in DONE must still kill the writeback of that cycle.
    assign wb_valid     = wb_valid_q && !flush;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_exception = wb_exc_q;
    // Low in DONE so the instruction leaves X on the DONE edge; forced low while in reset.
    assign stall        = !reset && (((state_q == StIdle) && op_valid && !flush) ||
                                     (state_q == StIssue) || (state_q == StWait));

endmodule
